// File: rtl/sodor5_iltype_stim_gen_if.sv
// Instruction-port handshake between the I-type stimulus generator and the Sodor wrapper.
interface sodor5_iltype_stim_gen_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic        is_load;

  modport master (output instr_valid, output instr, output is_load, input instr_ready);
  modport slave  (input instr_valid, input instr, input is_load, output instr_ready);
endinterface

// File: rtl/sodor5_iltype_stim_gen.sv
// Random I-type ALU / load instruction source with NOP warm-up and instruction budget.
// Optional macro ILGEN_HAZARD_EN: odd-count words reuse the previous random word's rd as rs1.
module sodor5_iltype_stim_gen #(
  parameter int NUM_INSTR   = 64,
  parameter int WARMUP_NOPS = 4,
  parameter int COUNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [31:0]                seed_i,
  input  logic                       start,
  sodor5_iltype_stim_gen_if.master   bus,
  output logic [COUNT_W-1:0]         count,
  output logic                       done
);

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
  localparam int NOP_W = (WARMUP_NOPS > 1) ? $clog2(WARMUP_NOPS) : 1;
  localparam logic [NOP_W-1:0]   NOP_LAST = NOP_W'(WARMUP_NOPS - 1);
  localparam logic [COUNT_W-1:0] BUDGET   = COUNT_W'(NUM_INSTR);

  typedef enum logic [1:0] {IDLE, WARM, RUN, DONE} state_t;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
  endfunction

  state_t             state_reg, state_next;
  logic [31:0]        lfsr_reg, lfsr_next;
  logic [31:0]        instr_reg, instr_next;
  logic               is_load_reg, is_load_next;
  logic [COUNT_W-1:0] count_reg, count_next;
  logic               done_reg, done_next;
  logic [NOP_W-1:0]   nop_cnt_reg, nop_cnt_next;
`ifdef ILGEN_HAZARD_EN
  logic [4:0]         last_rd_reg, last_rd_next;
`endif

  logic        xfer, gen_word;
  logic [31:0] lfsr_l1, lfsr_l2;
  logic [11:0] imm_alu, imm_l;
  logic [4:0]  gen_rs1, rd;
  logic [2:0]  funct3, funct3_l;
  logic        choice;

  assign xfer     = bus.instr_valid & bus.instr_ready;
  assign lfsr_l1  = lfsr_step(lfsr_reg);
  assign lfsr_l2  = lfsr_step(lfsr_l1);
  // W = {L1, L2}: L2 supplies W[31:0], L1 supplies W[63:32]
  assign rd       = lfsr_l2[21:17];
  assign funct3   = lfsr_l2[24:22];
  assign funct3_l = {lfsr_l2[27], 2'b00};
  assign imm_l    = {lfsr_l1[7:0], lfsr_l2[31:28]};
  assign choice   = lfsr_l1[8];

  // Shift immediates keep only shamt and the SRAI selector bit.
  always_comb begin
    imm_alu = lfsr_l2[11:0];
    if (funct3 == 3'd5)
      imm_alu = lfsr_l2[11:0] & 12'h41F;
    else if (funct3 == 3'd1)
      imm_alu = lfsr_l2[11:0] & 12'h01F;
  end

  always_comb begin
    state_next   = state_reg;
    lfsr_next    = lfsr_reg;
    instr_next   = instr_reg;
    is_load_next = is_load_reg;
    count_next   = count_reg;
    done_next    = done_reg;
    nop_cnt_next = nop_cnt_reg;
    gen_word     = 1'b0;
    gen_rs1      = lfsr_l2[16:12];
`ifdef ILGEN_HAZARD_EN
    last_rd_next = last_rd_reg;
`endif
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          count_next   = '0;
          done_next    = 1'b0;
          nop_cnt_next = '0;
          instr_next   = NOP;
          is_load_next = 1'b0;
`ifdef ILGEN_HAZARD_EN
          last_rd_next = '0;
`endif
          if (WARMUP_NOPS == 0) begin
            state_next = RUN;
            gen_word   = 1'b1;
          end else begin
            state_next = WARM;
          end
        end
      end
      WARM: begin
        if (xfer) begin
          nop_cnt_next = nop_cnt_reg + NOP_W'(1);
          if (nop_cnt_reg == NOP_LAST) begin
            state_next = RUN;
            gen_word   = 1'b1;
          end
        end
      end
      RUN: begin
        if (xfer) begin
          if (count_reg != '1)
            count_next = count_reg + COUNT_W'(1);
`ifdef ILGEN_HAZARD_EN
          last_rd_next = instr_reg[11:7];
`endif
          if ((NUM_INSTR != 0) && (count_next == BUDGET)) begin
            state_next   = DONE;
            done_next    = 1'b1;
            instr_next   = NOP;
            is_load_next = 1'b0;
          end else begin
            gen_word = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Next word is built on the edge that retires the current one: no bubbles.
    if (gen_word) begin
`ifdef ILGEN_HAZARD_EN
      if (count_next[0])
        gen_rs1 = last_rd_next;
`endif
      lfsr_next = lfsr_l2;
      if (choice) begin
        instr_next   = {imm_alu, gen_rs1, funct3, rd, 7'b0010011};
        is_load_next = 1'b0;
      end else begin
        instr_next   = {imm_l, gen_rs1, funct3_l, rd, 7'b0000011};
        is_load_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      lfsr_reg    <= (seed_i == 32'd0) ? 32'h0000_0001 : seed_i;
      instr_reg   <= NOP;
      is_load_reg <= 1'b0;
      count_reg   <= '0;
      done_reg    <= 1'b0;
      nop_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      lfsr_reg    <= lfsr_next;
      instr_reg   <= instr_next;
      is_load_reg <= is_load_next;
      count_reg   <= count_next;
      done_reg    <= done_next;
      nop_cnt_reg <= nop_cnt_next;
    end
  end

`ifdef ILGEN_HAZARD_EN
  always_ff @(posedge clk) begin
    if (!reset_n)
      last_rd_reg <= '0;
    else
      last_rd_reg <= last_rd_next;
  end
`endif

  assign bus.instr_valid = (state_reg != IDLE);
  assign bus.instr       = instr_reg;
  assign bus.is_load     = is_load_reg;
  assign count           = count_reg;
  assign done            = done_reg;

endmodule

// File: tb/tb_sodor5_iltype_stim_gen.sv
// Scoreboard bench for sodor5_iltype_stim_gen: directed words from seed 0, stalls, long legality run.
module tb_sodor5_iltype_stim_gen;

  localparam int NUM_INSTR   = 8;
  localparam int WARMUP_NOPS = 4;
  localparam int COUNT_W     = 16;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic [31:0]        seed_i = 32'd0;
  logic               start = 1'b0;
  logic [COUNT_W-1:0] count;
  logic               done;

  sodor5_iltype_stim_gen_if bus();

  sodor5_iltype_stim_gen #(
    .NUM_INSTR(NUM_INSTR), .WARMUP_NOPS(WARMUP_NOPS), .COUNT_W(COUNT_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .seed_i(seed_i), .start(start),
    .bus(bus), .count(count), .done(done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [32:0] exp_q[$];
  bit prop_mode = 1'b0;

  // Hand-stepped from lfsr = 1 (seed 0): words 1..7 are LB/LBU, word 8 is SLTIU.
  logic [31:0] rand_words [8] = '{
    32'h03C00C03, 32'h01B00B03, 32'h02684683, 32'h03D64D83,
    32'h01BD8B03, 32'h026B4A83, 32'h03D6C683, 32'h6C35BD93};
  logic rand_loads [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [32:0] exp_word(input int i);
    logic [31:0] w;
    w = rand_words[i];
`ifdef ILGEN_HAZARD_EN
    if (i % 2 == 1) begin
      logic [31:0] p;
      p = rand_words[i-1];
      w[19:15] = p[11:7];
    end
`endif
    return {rand_loads[i], w};
  endfunction

  task automatic push_run();
    for (int i = 0; i < WARMUP_NOPS; i++) exp_q.push_back({1'b0, NOP});
    for (int i = 0; i < NUM_INSTR; i++) exp_q.push_back(exp_word(i));
    exp_q.push_back({1'b0, NOP});
  endtask

  task automatic do_reset(input logic [31:0] s);
    @(posedge clk); #1;
    reset_n = 1'b0;
    seed_i  = s;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Monitor: scoreboard pops, stall stability and legality checks.
  initial begin
    logic        prev_stall;
    logic [32:0] prev_word;
    logic [32:0] e;
    logic [31:0] w;
    prev_stall = 1'b0;
    prev_word  = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall)
          cmp("stall_hold", {31'd0, bus.is_load, bus.instr}, {31'd0, prev_word});
        if (bus.instr_valid && bus.instr_ready) begin
          w = bus.instr;
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            $display("xfer instr=0x%08h is_load=%0d count=%0d", w, bus.is_load, count);
            cmp("sb_word", {31'd0, bus.is_load, w}, {31'd0, e});
          end else if (prop_mode) begin
            cmp("opcode_legal", 64'(w[6:0] == 7'h13 || w[6:0] == 7'h03), 64'd1);
            cmp("is_load_match", 64'(bus.is_load), 64'(w[6:0] == 7'h03));
            if (w[6:0] == 7'h13 && w[14:12] == 3'd5)
              cmp("srli_srai_imm", 64'(w[31:25] == 7'h00 || w[31:25] == 7'h20), 64'd1);
            if (w[6:0] == 7'h13 && w[14:12] == 3'd1)
              cmp("slli_imm", 64'(w[31:25]), 64'd0);
            if (w[6:0] == 7'h03)
              cmp("load_funct3", 64'(w[14:12] == 3'd0 || w[14:12] == 3'd4), 64'd1);
          end
        end
        prev_stall = bus.instr_valid && !bus.instr_ready;
        prev_word  = {bus.is_load, bus.instr};
      end
    end
  end

  initial begin
    int exp_cnt;
    bool_loop: begin end
    bus.instr_ready = 1'b0;

    // Reset with seed 0, idle without start.
    do_reset(32'd0);
    repeat (5) begin
      @(negedge clk);
      cmp("idle_valid", 64'(bus.instr_valid), 64'd0);
      cmp("idle_instr", 64'(bus.instr), 64'(NOP));
      cmp("idle_is_load", 64'(bus.is_load), 64'd0);
      cmp("idle_count", 64'(count), 64'd0);
      cmp("idle_done", 64'(done), 64'd0);
    end

    // Full-throughput run; a stray start mid-RUN must be ignored.
    bus.instr_ready = 1'b1;
    push_run();
    pulse_start();
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      exp_cnt = (k <= 5) ? 0 : ((k - 5 > NUM_INSTR) ? NUM_INSTR : k - 5);
      cmp("run_valid", 64'(bus.instr_valid), 64'd1);
      cmp("run_count", 64'(count), 64'(exp_cnt));
      cmp("run_done", 64'(done), 64'(k >= 13));
      start = (k == 8);
    end
    start = 1'b0;
    cmp("done_nop", 64'(bus.instr), 64'(NOP));
    cmp("run_queue_empty", 64'(exp_q.size()), 64'd0);

    // Same seed, random back-pressure: identical sequence expected.
    do_reset(32'd0);
    push_run();
    pulse_start();
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      bus.instr_ready = 1'($urandom_range(0, 1));
      if (done && exp_q.size() == 0) break;
    end
    @(negedge clk);
    cmp("stall_queue_empty", 64'(exp_q.size()), 64'd0);
    cmp("stall_done", 64'(done), 64'd1);
    cmp("stall_count", 64'(count), 64'(NUM_INSTR));

    // 10000 random words from seed 877 across repeated budget runs.
    bus.instr_ready = 1'b1;
    do_reset(32'd877);
    prop_mode = 1'b1;
    for (int r = 0; r < 10000 / NUM_INSTR; r++) begin
      bit seen;
      seen = 1'b0;
      pulse_start();
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (done) begin
          seen = 1'b1;
          break;
        end
      end
      if (!seen) begin
        cmp("long_done_timeout", 64'(done), 64'd1);
        break;
      end
      cmp("long_count", 64'(count), 64'(NUM_INSTR));
    end
    prop_mode = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sodor5_iltype_stim_gen.md
Name: sodor5_iltype_stim_gen

Overview:
- Synthesizable random instruction source that drives the instruction port of the Sodor 5-stage verification wrapper.
- Emits a stream of random I-type ALU and load instructions, pseudo-randomly interleaved. All fields are legal and shift immediates are masked.
- Replaces the behavioural stimulus process so the same stream runs in simulation, emulation and formal harnesses.
- Uses a valid/ready handshake, a warm-up NOP phase and an instruction budget.

Parameters:
- NUM_INSTR, 64: random instructions emitted per run; 0 = unlimited (never reaches DONE).
- WARMUP_NOPS, 4: NOPs (0x00000013) emitted after start and before random instructions.
- COUNT_W, 16: width of the instruction counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- seed_i  in  32  LFSR seed, sampled while reset_n=0.
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE.
- instr_ready  in  1  consumer accepts instr this cycle.
- instr_valid  out  1  instr is meaningful.
- instr  out  32  instruction word.
- is_load  out  1  current instr is a load (opcode 0000011).
- count  out  COUNT_W  random instructions accepted this run.
- done  out  1  budget exhausted.

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - state=IDLE, instr_valid=0, instr=0x00000013, is_load=0, count=0, done=0.
  - lfsr=seed_i; if seed_i=0, lfsr=0x00000001.
- LFSR:
  - 32-bit Galois, mask 0x80200003, one step per shift.
  - Each random instruction uses W={L1,L2}, where L1 = lfsr stepped once and L2 = stepped twice.
  - On acceptance of a random instruction, lfsr<=L2.
- Field slices from W:
  - imm=W[11:0], rs1=W[16:12], rd=W[21:17], funct3=W[24:22].
  - funct3_l=W[27:25]&3'b100, so loads are LB or LBU only.
  - imm_l=W[39:28], choice=W[40].
- Shift masking:
  - funct3=5: imm&=0x41F.
  - funct3=1: imm&=0x01F.
- Encoding:
  - choice=1: {imm,rs1,funct3,rd,0010011}.
  - choice=0: {imm_l,rs1,funct3_l,rd,0000011}.
- Handshake:
  - Transfer = instr_valid & instr_ready.
  - While instr_valid=1 and instr_ready=0, instr and is_load hold stable.
  - The next word is registered on the transfer edge, so one word is available per cycle with zero bubbles at full throughput.
- FSM:
  - IDLE: valid=0. start -> WARM. The first NOP is presented the next cycle.
  - WARM: valid=1, instr=NOP. Internal nop counter counts transfers. After WARMUP_NOPS transfers -> RUN, with the first random word registered on the last NOP transfer. If WARMUP_NOPS=0, go IDLE->RUN directly.
  - RUN: valid=1, random words. count increments per transfer.
    - On the transfer where count becomes NUM_INSTR (NUM_INSTR≠0): -> DONE, done<=1, instr<=NOP.
    - count saturates at all-ones.
  - DONE: valid=1, instr=NOP forever, so the pipeline drains.
    - start -> WARM, with count=0 and done=0. The LFSR is not reseeded, so the stream continues.
- start outside IDLE/DONE is ignored.
- Reset asserted mid-run: full reset next edge; any partially handshaked word is dropped.
- is_load is registered alongside instr. It is 0 for NOPs.

Optional Feature:
- Macro ILGEN_HAZARD_EN.
- Defined:
  - In RUN, every second random instruction (odd count) forces rs1 := rd of the previously accepted random instruction.
  - This creates back-to-back RAW dependencies, including load-use hazards.
  - The last-rd register is cleared on reset and on start.
- Undefined:
  - rs1 always comes from the LFSR.
  - No extra register is present.

Test Plan:
- Reset with seed_i=0, release, no start for 5 cycles -> instr_valid=0, instr=0x00000013, count=0, done=0 throughout.
- start, instr_ready=1 constant, WARMUP_NOPS=4 -> exactly 4 consecutive 0x00000013 words, then a random word on the 5th valid cycle.
- NUM_INSTR=4, instr_ready=1 -> count steps 1,2,3,4. done=1 on the cycle after the 4th transfer, with instr=0x00000013 and valid=1 thereafter.
- Random stream, instr_ready toggled by a 50% random pattern -> instr is stable through every stall, no word is lost or duplicated, and the sequence equals the instr_ready=1 run with the same seed.
- 10000 instructions, seed 877 -> opcode always in {0x13,0x03}.
  - funct3=5 ALU words have imm[11:5] ∈ {0x00,0x20}.
  - funct3=1 words have imm[11:5]=0.
  - Load funct3 ∈ {0,4}.
  - is_load matches opcode.
- ILGEN_HAZARD_EN defined, NUM_INSTR=8 -> in random words 2, 4, 6 and 8, rs1 (bits 19:15) equals rd (bits 11:7) of the preceding random word.
